// File: rtl/stream_id_demux.sv
// Return-path splitter: routes each packet of a merged stream to the output selected by its head id.
// Every output sits behind a 2-entry FIFO; packets with an id beyond the output count are dropped and counted.
module stream_id_demux #(
    parameter int  T_DATA_WIDTH   = 8,
    parameter int  S_DATA_COUNT   = 2,
    parameter int  DROP_CNT_WIDTH = 16,
    localparam int T_ID___WIDTH   = $clog2(S_DATA_COUNT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [T_DATA_WIDTH-1:0]   s_data_i,
    input  logic [T_ID___WIDTH-1:0]   s_id_i,
    input  logic                      s_last_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [T_DATA_WIDTH-1:0]   m_data_o [S_DATA_COUNT],
    output logic [S_DATA_COUNT-1:0]   m_last_o,
    output logic [S_DATA_COUNT-1:0]   m_valid_o,
    input  logic [S_DATA_COUNT-1:0]   m_ready_i,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    localparam int ID_SPACE = 2 ** T_ID___WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [T_ID___WIDTH-1:0]   r_lock_id;
    logic                      r_run;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
    logic [1:0]                r_count     [S_DATA_COUNT];
    logic [T_DATA_WIDTH-1:0]   r_head_data [S_DATA_COUNT];
    logic [T_DATA_WIDTH-1:0]   r_tail_data [S_DATA_COUNT];
    logic [S_DATA_COUNT-1:0]   r_head_last;
    logic [S_DATA_COUNT-1:0]   r_tail_last;
    logic [S_DATA_COUNT-1:0]   r_valid;

    logic [ID_SPACE-1:0]       w_id_known;
    logic [T_ID___WIDTH-1:0]   w_sel;
    logic                      w_sel_known;
    logic                      w_sel_can;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_drop_done;
    logic [S_DATA_COUNT-1:0]   w_push;
    logic [S_DATA_COUNT-1:0]   w_pop;
    logic [1:0]                w_count_nxt [S_DATA_COUNT];

    // Target selection, input readiness and per-output push/pop strobes
    always_comb begin
        w_sel       = r_lock_id;
        w_sel_known = 1'b0;
        w_sel_can   = 1'b0;
        for (int i = 0; i < ID_SPACE; i++) begin
            w_id_known[i] = (i < S_DATA_COUNT);
        end
        case (r_state)
            IDLE: begin
                w_sel       = s_id_i;
                w_sel_known = w_id_known[s_id_i];
            end
            ROUTE:   w_sel_known = 1'b1;
            DROP:    w_sel_known = 1'b0;
            default: w_sel_known = 1'b0;
        endcase
        // Readiness uses only registered occupancy, so there is no path from m_ready_i.
        for (int k = 0; k < S_DATA_COUNT; k++) begin
            w_sel_can = w_sel_can | ((w_sel == T_ID___WIDTH'(k)) & (r_count[k] != 2'd2));
        end
        w_ready     = r_run & (w_sel_known ? w_sel_can : 1'b1);
        w_accept    = s_valid_i & w_ready;
        w_drop_done = w_accept & ~w_sel_known & s_last_i;
        for (int k = 0; k < S_DATA_COUNT; k++) begin
            w_push[k]      = w_accept & w_sel_known & (w_sel == T_ID___WIDTH'(k));
            w_pop[k]       = r_valid[k] & m_ready_i[k];
            w_count_nxt[k] = r_count[k] + {1'b0, w_push[k]} - {1'b0, w_pop[k]};
        end
    end

    // Packet-level state: head detection, locked destination and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_lock_id  <= '0;
            r_run      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_drop_done && (r_drop_cnt != {DROP_CNT_WIDTH{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
            end
            if (w_accept) begin
                case (r_state)
                    IDLE: begin
                        if (!s_last_i) begin
                            r_state   <= w_sel_known ? ROUTE : DROP;
                            r_lock_id <= s_id_i;
                        end
                    end
                    ROUTE, DROP: begin
                        if (s_last_i) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Per-output 2-entry FIFO kept as head/tail registers so outputs come straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < S_DATA_COUNT; k++) begin
                r_count[k]     <= 2'd0;
                r_head_data[k] <= '0;
                r_tail_data[k] <= '0;
            end
            r_head_last <= '0;
            r_tail_last <= '0;
            r_valid     <= '0;
        end else begin
            for (int k = 0; k < S_DATA_COUNT; k++) begin
                r_count[k] <= w_count_nxt[k];
                r_valid[k] <= (w_count_nxt[k] != 2'd0);
                case ({w_push[k], w_pop[k]})
                    2'b10: begin
                        if (r_count[k] == 2'd0) begin
                            r_head_data[k] <= s_data_i;
                            r_head_last[k] <= s_last_i;
                        end else begin
                            r_tail_data[k] <= s_data_i;
                            r_tail_last[k] <= s_last_i;
                        end
                    end
                    2'b01: begin
                        r_head_data[k] <= r_tail_data[k];
                        r_head_last[k] <= r_tail_last[k];
                    end
                    2'b11: begin
                        if (r_count[k] == 2'd1) begin
                            r_head_data[k] <= s_data_i;
                            r_head_last[k] <= s_last_i;
                        end else begin
                            r_head_data[k] <= r_tail_data[k];
                            r_head_last[k] <= r_tail_last[k];
                            r_tail_data[k] <= s_data_i;
                            r_tail_last[k] <= s_last_i;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_ready_o  = w_ready;
    assign m_data_o   = r_head_data;
    assign m_last_o   = r_head_last;
    assign m_valid_o  = r_valid;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_stream_id_demux.sv
// Bench for stream_id_demux: a 2-output and a 3-output (narrow drop counter) instance, checked every
// cycle against a queue-based packet model, plus directed scenarios with literal expectations.
module tb_stream_id_demux;

    logic       clk;
    logic       rst_n;

    logic       a_valid, a_last, a_sready;
    logic [0:0] a_id;
    logic [7:0] a_data;
    logic [7:0] a_mdata [2];
    logic [1:0] a_mlast, a_mvalid, a_mready;
    logic [15:0] a_drop;

    logic       b_valid, b_last, b_sready;
    logic [1:0] b_id;
    logic [7:0] b_data;
    logic [7:0] b_mdata [3];
    logic [2:0] b_mlast, b_mvalid, b_mready;
    logic [1:0] b_drop;

    int n_chk = 0;
    int n_err = 0;

    stream_id_demux #(.T_DATA_WIDTH(8), .S_DATA_COUNT(2), .DROP_CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_data_i(a_data), .s_id_i(a_id), .s_last_i(a_last),
        .s_valid_i(a_valid), .s_ready_o(a_sready), .m_data_o(a_mdata), .m_last_o(a_mlast),
        .m_valid_o(a_mvalid), .m_ready_i(a_mready), .drop_cnt_o(a_drop));

    stream_id_demux #(.T_DATA_WIDTH(8), .S_DATA_COUNT(3), .DROP_CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data_i(b_data), .s_id_i(b_id), .s_last_i(b_last),
        .s_valid_i(b_valid), .s_ready_o(b_sready), .m_data_o(b_mdata), .m_last_o(b_mlast),
        .m_valid_o(b_mvalid), .m_ready_i(b_mready), .drop_cnt_o(b_drop));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one queue per output holds every beat delivered but not yet consumed;
    // the buffer depth is 2, so a destination can take a beat while its queue holds fewer than 2.
    int         m_st   [2];   // 0 = between packets, 1 = inside routed packet, 2 = inside dropped packet
    int         m_lock [2];
    int         m_dcnt [2];
    bit         m_run  [2];
    logic [8:0] m_q    [6][$];

    int         c_nout, c_iid, c_cap, c_dst, c_qi;
    bit         c_iv, c_il, c_prdy, c_acc, c_expv;
    logic [7:0] c_idat;
    logic [7:0] c_od [3];
    logic [2:0] c_ov, c_ol, c_mr;
    logic [15:0] c_drp;
    logic       c_rdy;
    logic [8:0] c_head;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                c_nout = 2; c_cap = 65535;
                c_iv = a_valid; c_il = a_last; c_iid = int'(a_id); c_idat = a_data;
                c_ov = {1'b0, a_mvalid}; c_ol = {1'b0, a_mlast}; c_mr = {1'b0, a_mready};
                c_od[0] = a_mdata[0]; c_od[1] = a_mdata[1]; c_od[2] = 8'h00;
                c_drp = a_drop; c_rdy = a_sready;
            end else begin
                c_nout = 3; c_cap = 3;
                c_iv = b_valid; c_il = b_last; c_iid = int'(b_id); c_idat = b_data;
                c_ov = b_mvalid; c_ol = b_mlast; c_mr = b_mready;
                c_od[0] = b_mdata[0]; c_od[1] = b_mdata[1]; c_od[2] = b_mdata[2];
                c_drp = {14'd0, b_drop}; c_rdy = b_sready;
            end
            if (!rst_n) begin
                for (int k = 0; k < 3; k++) m_q[d*3+k].delete();
                m_st[d] = 0; m_dcnt[d] = 0; m_run[d] = 1'b0;
                chk($sformatf("d%0d_rst_valid", d), 32'(c_ov), 32'd0);
                chk($sformatf("d%0d_rst_ready", d), 32'(c_rdy), 32'd0);
                chk($sformatf("d%0d_rst_drop", d), 32'(c_drp), 32'd0);
            end else begin
                for (int k = 0; k < c_nout; k++) begin
                    c_qi = d*3 + k;
                    c_expv = (m_q[c_qi].size() != 0);
                    chk($sformatf("d%0d_valid%0d", d, k), 32'(c_ov[k]), 32'(c_expv));
                    if (c_expv) begin
                        c_head = m_q[c_qi][0];
                        chk($sformatf("d%0d_data%0d", d, k), 32'(c_od[k]), 32'(c_head[7:0]));
                        chk($sformatf("d%0d_last%0d", d, k), 32'(c_ol[k]), 32'(c_head[8]));
                    end
                end
                chk($sformatf("d%0d_drop", d), 32'(c_drp), 32'(m_dcnt[d]));
                c_dst = (m_st[d] == 1) ? m_lock[d] : c_iid;
                if (!m_run[d])
                    c_prdy = 1'b0;
                else if (m_st[d] == 2 || (m_st[d] == 0 && c_iid >= c_nout))
                    c_prdy = 1'b1;
                else
                    c_prdy = (m_q[d*3+c_dst].size() < 2);
                if (c_iv) chk($sformatf("d%0d_ready", d), 32'(c_rdy), 32'(c_prdy));
                c_acc = c_iv && c_prdy;
                for (int k = 0; k < c_nout; k++) begin
                    if (m_q[d*3+k].size() != 0 && c_mr[k]) void'(m_q[d*3+k].pop_front());
                end
                if (c_acc) begin
                    if (m_st[d] == 2) begin
                        if (c_il) begin
                            m_st[d] = 0;
                            if (m_dcnt[d] < c_cap) m_dcnt[d]++;
                        end
                    end else if (m_st[d] == 0 && c_iid >= c_nout) begin
                        if (c_il) begin
                            if (m_dcnt[d] < c_cap) m_dcnt[d]++;
                        end else begin
                            m_st[d] = 2;
                        end
                    end else begin
                        m_q[d*3+c_dst].push_back({c_il, c_idat});
                        if (c_il) m_st[d] = 0;
                        else begin m_st[d] = 1; m_lock[d] = c_dst; end
                    end
                end
                m_run[d] = 1'b1;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b1; a_last = 1'b0; a_id = 1'b0; a_data = 8'h00; a_mready = 2'b11;
        b_valid = 1'b1; b_last = 1'b0; b_id = 2'd0; b_data = 8'h00; b_mready = 3'b111;
        #3;
        chk("rst_a_valid", 32'(a_mvalid), 32'd0);
        chk("rst_a_ready", 32'(a_sready), 32'd0);
        chk("rst_a_drop", 32'(a_drop), 32'd0);
        chk("rst_a_data0", 32'(a_mdata[0]), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step(); step();

        // Single-beat packets back to back
        a_valid = 1'b1; a_id = 1'b0; a_data = 8'hA5; a_last = 1'b1; #1;
        chk("t1_ready0", 32'(a_sready), 32'd1);
        step();
        a_id = 1'b1; a_data = 8'h3C; #1;
        chk("t1_valid0", 32'(a_mvalid[0]), 32'd1);
        chk("t1_data0", 32'(a_mdata[0]), 32'hA5);
        chk("t1_ready1", 32'(a_sready), 32'd1);
        step();
        a_valid = 1'b0; #1;
        chk("t1_valid1", 32'(a_mvalid), 32'b10);
        chk("t1_data1", 32'(a_mdata[1]), 32'h3C);

        // Packet lock: id changes after the head are ignored
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_id = (i == 0) ? 1'b1 : 1'b0;
            a_data = 8'(8'h10 + i); a_last = (i == 3); #1;
            chk("t2_ready", 32'(a_sready), 32'd1);
            step();
            a_valid = 1'b0; #1;
            chk("t2_valid", 32'(a_mvalid), 32'b10);
            chk("t2_data", 32'(a_mdata[1]), 32'(8'h10 + i));
            chk("t2_last", 32'(a_mlast[1]), 32'(i == 3));
        end

        // Backpressure fills output 0, then drains without loss
        a_mready = 2'b10;
        for (int i = 0; i < 2; i++) begin
            a_valid = 1'b1; a_id = 1'b0; a_data = 8'(8'h20 + i); a_last = 1'b0; #1;
            chk("t3_ready", 32'(a_sready), 32'd1);
            step();
        end
        a_data = 8'h22; a_last = 1'b1; #1;
        chk("t3_full_ready", 32'(a_sready), 32'd0);
        chk("t3_hold_data", 32'(a_mdata[0]), 32'h20);
        step();
        chk("t3_hold_data2", 32'(a_mdata[0]), 32'h20);
        a_mready = 2'b11; #1;
        chk("t3_ready_no_comb", 32'(a_sready), 32'd0);
        step();
        chk("t3_ready_after", 32'(a_sready), 32'd1);
        chk("t3_data1", 32'(a_mdata[0]), 32'h21);
        step();
        a_valid = 1'b0; #1;
        chk("t3_data2", 32'(a_mdata[0]), 32'h22);
        chk("t3_last2", 32'(a_mlast[0]), 32'd1);
        step();
        chk("t3_empty", 32'(a_mvalid), 32'd0);

        // Output 1 stalled and full while output 0 streams
        a_mready = 2'b01;
        for (int i = 0; i < 2; i++) begin
            a_valid = 1'b1; a_id = 1'b1; a_data = 8'(8'h40 + i); a_last = 1'b1;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_id = 1'b0; a_data = 8'(8'h50 + i); a_last = (i == 2); #1;
            chk("t6_ready", 32'(a_sready), 32'd1);
            step();
            a_valid = 1'b0; #1;
            chk("t6_data0", 32'(a_mdata[0]), 32'(8'h50 + i));
            chk("t6_valid", 32'(a_mvalid), 32'b11);
            chk("t6_held1", 32'(a_mdata[1]), 32'h40);
        end
        a_mready = 2'b11;
        repeat (3) step();

        // Asynchronous reset while routing with output 0 holding two beats
        a_mready = 2'b10;
        for (int i = 0; i < 2; i++) begin
            a_valid = 1'b1; a_id = 1'b0; a_data = 8'(8'h60 + i); a_last = 1'b0;
            step();
        end
        a_data = 8'h62; #1;
        chk("t5_full", 32'(a_sready), 32'd0);
        chk("t5_valid_pre", 32'(a_mvalid), 32'b01);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid_rst", 32'(a_mvalid), 32'd0);
        chk("t5_ready_rst", 32'(a_sready), 32'd0);
        chk("t5_data_rst", 32'(a_mdata[0]), 32'd0);
        step(); step();
        a_valid = 1'b0; a_mready = 2'b11;
        #2 rst_n = 1'b1;
        step(); step();
        a_valid = 1'b1; a_id = 1'b1; a_data = 8'h77; a_last = 1'b1; #1;
        chk("t5_head_ready", 32'(a_sready), 32'd1);
        step();
        a_valid = 1'b0; #1;
        chk("t5_head_valid", 32'(a_mvalid), 32'b10);
        chk("t5_head_data", 32'(a_mdata[1]), 32'h77);

        // Out-of-range id on the 3-output instance: dropped, counted, saturating at 3
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1; b_id = 2'd3; b_data = 8'(i); b_last = (i == 2); #1;
            chk("t4_ready", 32'(b_sready), 32'd1);
            step();
        end
        b_valid = 1'b0; #1;
        chk("t4_drop1", 32'(b_drop), 32'd1);
        chk("t4_novalid", 32'(b_mvalid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1; b_id = 2'd3; b_last = 1'b1; #1;
            chk("t4_ready1", 32'(b_sready), 32'd1);
            step();
            b_valid = 1'b0; #1;
            chk("t4_dropn", 32'(b_drop), (i == 0) ? 32'd2 : 32'd3);
        end
        b_valid = 1'b1; b_id = 2'd2; b_data = 8'h99; b_last = 1'b1;
        step();
        b_valid = 1'b0; #1;
        chk("t4_route2_valid", 32'(b_mvalid), 32'b100);
        chk("t4_route2_data", 32'(b_mdata[2]), 32'h99);
        chk("t4_drop_keep", 32'(b_drop), 32'd3);

        // Randomized traffic: light stalls, then heavy stalls
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                @(posedge clk); #1;
                a_valid = ($urandom_range(3) != 0); a_id = 1'($urandom_range(1));
                a_data = 8'($urandom); a_last = ($urandom_range(2) == 0);
                b_valid = ($urandom_range(3) != 0); b_id = 2'($urandom_range(3));
                b_data = 8'($urandom); b_last = ($urandom_range(2) == 0);
                for (int k = 0; k < 2; k++) a_mready[k] = (ph == 0) ? ($urandom_range(3) != 0) : ($urandom_range(1) == 0);
                for (int k = 0; k < 3; k++) b_mready[k] = (ph == 0) ? ($urandom_range(3) != 0) : ($urandom_range(1) == 0);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0; a_mready = 2'b11; b_mready = 3'b111;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
